// File: rtl/int_seq.sv
// rtl/int_seq.sv - interrupt sequencer: pin sync, NMI edge latch, RST/NMI/IRQ arbitration at sync.
// Optional WAI wait state enabled by defining INT_SEQ_WAI_EN.
module int_seq #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       irq,
    input  logic       nmi,
    input  logic       sync,
    input  logic       I,
    input  logic       vec_ack,
    output logic       take_int,
    output logic [7:0] vec_lo,
    output logic       B,
    output logic       int_busy
`ifdef INT_SEQ_WAI_EN
    ,
    input  logic       wai,
    output logic       rdy
`endif
);

    typedef enum logic {
        IDLE,
        SERVICE
    } state_t;

    typedef enum logic [1:0] {
        SRC_RST,
        SRC_NMI,
        SRC_IRQ
    } src_t;

    logic   irq_s;
    logic   nmi_s;
    logic   nmi_prev;
    logic   nmi_pend;
    logic   rst_pend;
    state_t state;
    src_t   src;
    src_t   win_src;
    logic   any_src;
    logic   sync_ok;
    logic   nmi_edge;
    logic   ack_rst;
    logic   ack_nmi;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign irq_s = irq;
            assign nmi_s = nmi;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] irq_q;
            logic [SYNC_STAGES-1:0] nmi_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    irq_q <= '0;
                    nmi_q <= '0;
                end else begin
                    irq_q[0] <= irq;
                    nmi_q[0] <= nmi;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        irq_q[k] <= irq_q[k-1];
                        nmi_q[k] <= nmi_q[k-1];
                    end
                end
            end

            assign irq_s = irq_q[SYNC_STAGES-1];
            assign nmi_s = nmi_q[SYNC_STAGES-1];
        end
    endgenerate

`ifdef INT_SEQ_WAI_EN
    // Any pending source wakes the core, even an IRQ masked by I.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdy <= 1'b1;
        end else if (irq_s || nmi_pend || rst_pend) begin
            rdy <= 1'b1;
        end else if (wai) begin
            rdy <= 1'b0;
        end
    end
    assign sync_ok = sync & rdy;
`else
    assign sync_ok = sync;
`endif

    assign nmi_edge = nmi_s & ~nmi_prev;
    assign ack_rst  = (state == SERVICE) && vec_ack && (src == SRC_RST);
    assign ack_nmi  = (state == SERVICE) && vec_ack && (src == SRC_NMI);
    assign any_src  = rst_pend | nmi_pend | (irq_s & ~I);

    always_comb begin
        win_src = SRC_IRQ;
        if (rst_pend) begin
            win_src = SRC_RST;
        end else if (nmi_pend) begin
            win_src = SRC_NMI;
        end
    end

    assign take_int = sync_ok && (state == IDLE) && !reset && any_src;

    always_ff @(posedge clk) begin
        if (reset) begin
            nmi_prev <= 1'b0;
            nmi_pend <= 1'b0;
            rst_pend <= 1'b1;
            state    <= IDLE;
            src      <= SRC_RST;
        end else begin
            nmi_prev <= nmi_s;
            // A fresh edge beats a simultaneous acknowledge so that NMI is not lost.
            if (nmi_edge) begin
                nmi_pend <= 1'b1;
            end else if (ack_nmi) begin
                nmi_pend <= 1'b0;
            end
            if (ack_rst) begin
                rst_pend <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (take_int) begin
                        state <= SERVICE;
                        src   <= win_src;
                    end
                end
                SERVICE: begin
                    if (vec_ack) begin
                        state <= IDLE;
                    end else if (src == SRC_IRQ && nmi_pend) begin
                        src <= SRC_NMI;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        int_busy = 1'b0;
        B        = 1'b1;
        vec_lo   = rst_pend ? 8'hFC : 8'hFE;
        if (state == SERVICE) begin
            int_busy = 1'b1;
            case (src)
                SRC_RST: begin
                    B      = 1'b1;
                    vec_lo = 8'hFC;
                end
                SRC_NMI: begin
                    B      = 1'b0;
                    vec_lo = 8'hFA;
                end
                default: begin
                    B      = 1'b0;
                    vec_lo = 8'hFE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_seq.sv
// tb/tb_int_seq.sv - vector table and scoreboard bench for int_seq (SYNC_STAGES = 2).
module tb_int_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       irq;
    logic       nmi;
    logic       sync;
    logic       I;
    logic       vec_ack;
    logic       take_int;
    logic [7:0] vec_lo;
    logic       B;
    logic       int_busy;
    logic       wai;
    logic       rdy;

    always #5 clk = ~clk;

    int_seq #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .irq      (irq),
        .nmi      (nmi),
        .sync     (sync),
        .I        (I),
        .vec_ack  (vec_ack),
        .take_int (take_int),
        .vec_lo   (vec_lo),
        .B        (B),
        .int_busy (int_busy)
`ifdef INT_SEQ_WAI_EN
        ,
        .wai      (wai),
        .rdy      (rdy)
`endif
    );

    typedef struct {
        logic       rst;
        logic       irq;
        logic       nmi;
        logic       sync;
        logic       i;
        logic       ack;
        logic       wai;
        logic       take;
        logic [7:0] vec;
        logic       b;
        logic       busy;
    } vec_t;

    typedef struct {
        logic       take;
        logic [7:0] vec;
        logic       b;
        logic       busy;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t v(input logic r, input logic q, input logic n, input logic s,
                               input logic i, input logic a, input logic t,
                               input logic [7:0] vl, input logic b, input logic bz);
        vec_t x;
        x.rst = r; x.irq = q; x.nmi = n; x.sync = s; x.i = i; x.ack = a; x.wai = 1'b0;
        x.take = t; x.vec = vl; x.b = b; x.busy = bz;
        return x;
    endfunction

    // Drive one cycle's inputs at the falling edge, then compare settled outputs before the rising edge.
    task automatic apply(input vec_t x, input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset = x.rst; irq = x.irq; nmi = x.nmi; sync = x.sync;
        I = x.i; vec_ack = x.ack; wai = x.wai;
        e.take = x.take; e.vec = x.vec; e.b = x.b; e.busy = x.busy;
        exp_q.push_back(e);
        #1;
        got = exp_q.pop_front();
        n_vec++;
        if (take_int !== got.take || vec_lo !== got.vec || B !== got.b || int_busy !== got.busy) begin
            n_bad++;
            $display("FAIL %s: got take=%b vec=%h B=%b busy=%b, expected take=%b vec=%h B=%b busy=%b",
                     tag, take_int, vec_lo, B, int_busy, got.take, got.vec, got.b, got.busy);
        end
    endtask

    task automatic check_rdy(input logic exp, input string tag);
        n_vec++;
        if (rdy !== exp) begin
            n_bad++;
            $display("FAIL %s: rdy=%b expected %b", tag, rdy, exp);
        end
    endtask

    initial begin
        vec_t w;
        reset = 1'b1; irq = 1'b0; nmi = 1'b0; sync = 1'b0; I = 1'b0; vec_ack = 1'b0; wai = 1'b0;
        repeat (2) @(posedge clk);

        //          rst irq nmi syn I  ack take vec    B  busy
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 8'hFC, 1, 0)); // reset state, sync gated by reset
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 8'hFC, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, 8'hFC, 1, 0)); // reset sequence taken
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 8'hFC, 1, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 8'hFC, 1, 1)); // sync in SERVICE ignored
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 8'hFC, 1, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 8'hFE, 1, 0)); // no sources after rst ack
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 8'hFE, 1, 0)); // IRQ unmasked
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 8'hFE, 1, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0, 1, 8'hFE, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 8'hFE, 0, 1)); // irq dropped, still FE
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 8'hFE, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 8'hFE, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 8'hFE, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 0, 0, 8'hFE, 1, 0)); // IRQ masked by I
        tbl.push_back(v(0, 1, 0, 0, 1, 0, 0, 8'hFE, 1, 0));
        tbl.push_back(v(0, 1, 0, 1, 1, 0, 0, 8'hFE, 1, 0));
        tbl.push_back(v(0, 1, 0, 1, 1, 0, 0, 8'hFE, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 0, 0, 8'hFE, 1, 0)); // NMI pulse with I = 1
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 8'hFE, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 8'hFE, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 0, 1, 8'hFE, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 8'hFA, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 8'hFA, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 1, 0, 0, 8'hFE, 1, 0)); // nmi_pend cleared
        tbl.push_back(v(0, 0, 1, 0, 1, 0, 0, 8'hFE, 1, 0)); // NMI held high
        tbl.push_back(v(0, 0, 1, 0, 1, 0, 0, 8'hFE, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 0, 0, 8'hFE, 1, 0));
        tbl.push_back(v(0, 0, 1, 1, 1, 0, 1, 8'hFE, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 1, 0, 8'hFA, 0, 1));
        tbl.push_back(v(0, 0, 1, 1, 1, 0, 0, 8'hFE, 1, 0)); // no retrigger while held
        tbl.push_back(v(0, 0, 1, 1, 1, 0, 0, 8'hFE, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 8'hFE, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 8'hFE, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 8'hFE, 1, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k], $sformatf("tbl[%0d]", k));
        end

        // NMI hijacks an IRQ in service, then the still-high IRQ is serviced.
        apply(v(0, 1, 0, 0, 0, 0, 0, 8'hFE, 1, 0), "hij0");
        apply(v(0, 1, 0, 0, 0, 0, 0, 8'hFE, 1, 0), "hij1");
        apply(v(0, 1, 0, 1, 0, 0, 1, 8'hFE, 1, 0), "hij_take_irq");
        apply(v(0, 1, 1, 0, 0, 0, 0, 8'hFE, 0, 1), "hij3");
        apply(v(0, 1, 0, 0, 0, 0, 0, 8'hFE, 0, 1), "hij4");
        apply(v(0, 1, 0, 0, 0, 0, 0, 8'hFE, 0, 1), "hij5");
        apply(v(0, 1, 0, 0, 0, 0, 0, 8'hFE, 0, 1), "hij6");
        apply(v(0, 1, 0, 0, 0, 0, 0, 8'hFA, 0, 1), "hij_vec_fa");
        apply(v(0, 1, 0, 0, 0, 1, 0, 8'hFA, 0, 1), "hij_ack");
        apply(v(0, 1, 0, 1, 0, 0, 1, 8'hFE, 1, 0), "hij_irq_again");
        apply(v(0, 0, 0, 0, 0, 1, 0, 8'hFE, 0, 1), "hij_ack_irq");
        apply(v(0, 0, 0, 0, 0, 0, 0, 8'hFE, 1, 0), "hij_idle0");
        apply(v(0, 0, 0, 0, 0, 0, 0, 8'hFE, 1, 0), "hij_idle1");
        apply(v(0, 0, 0, 1, 0, 0, 0, 8'hFE, 1, 0), "hij_idle2");

        // NMI edge coincides with the NMI acknowledge, then reset in SERVICE.
        apply(v(0, 0, 1, 0, 1, 0, 0, 8'hFE, 1, 0), "col0");
        apply(v(0, 0, 0, 0, 1, 0, 0, 8'hFE, 1, 0), "col1");
        apply(v(0, 0, 0, 0, 1, 0, 0, 8'hFE, 1, 0), "col2");
        apply(v(0, 0, 0, 1, 1, 0, 1, 8'hFE, 1, 0), "col_take_nmi");
        apply(v(0, 0, 1, 0, 1, 0, 0, 8'hFA, 0, 1), "col4");
        apply(v(0, 0, 0, 0, 1, 0, 0, 8'hFA, 0, 1), "col5");
        apply(v(0, 0, 0, 0, 1, 1, 0, 8'hFA, 0, 1), "col_ack_edge");
        apply(v(0, 0, 0, 1, 1, 0, 1, 8'hFE, 1, 0), "col_second_nmi");
        apply(v(0, 0, 0, 0, 1, 0, 0, 8'hFA, 0, 1), "col8");
        apply(v(1, 0, 0, 0, 1, 0, 0, 8'hFA, 0, 1), "rst_in_service");
        apply(v(1, 0, 0, 1, 1, 0, 0, 8'hFC, 1, 0), "rst_state");
        apply(v(0, 0, 0, 0, 1, 0, 0, 8'hFC, 1, 0), "rst_released");
        apply(v(0, 0, 0, 1, 1, 0, 1, 8'hFC, 1, 0), "rst_take");
        apply(v(0, 0, 0, 0, 1, 1, 0, 8'hFC, 1, 1), "rst_ack");
        apply(v(0, 0, 0, 1, 1, 0, 0, 8'hFE, 1, 0), "rst_cleared_nmi");

`ifdef INT_SEQ_WAI_EN
        w = v(0, 0, 0, 0, 1, 0, 0, 8'hFE, 1, 0);
        w.wai = 1'b1;
        apply(w, "wai_pulse");
        check_rdy(1'b1, "rdy_before_wai");
        apply(v(0, 1, 0, 1, 1, 0, 0, 8'hFE, 1, 0), "wai_sleep");
        check_rdy(1'b0, "rdy_dropped");
        apply(v(0, 1, 0, 0, 1, 0, 0, 8'hFE, 1, 0), "wai2");
        check_rdy(1'b0, "rdy_still_low");
        apply(v(0, 1, 0, 0, 1, 0, 0, 8'hFE, 1, 0), "wai3");
        check_rdy(1'b0, "rdy_low_irq_s");
        apply(v(0, 1, 0, 1, 1, 0, 0, 8'hFE, 1, 0), "wai_woken_masked");
        check_rdy(1'b1, "rdy_woken");
`else
        w = v(0, 0, 0, 0, 0, 0, 0, 8'hFE, 1, 0);
        apply(w, "tail");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
